// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide unit beside the ALU.
// Shift-add multiply (LSB first) and restoring divide (MSB first) share one
// 2*WIDTH accumulator. Fixed latency regardless of op or operand values.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [4:0] OP_MULT  = 5'd16;
  localparam logic [4:0] OP_MULTU = 5'd17;
  localparam logic [4:0] OP_DIV   = 5'd18;
  localparam logic [4:0] OP_DIVU  = 5'd19;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [1:0]         op_q;          // low op bits: [1]=divide, [0]=unsigned
  logic [WIDTH-1:0]   opa_q;         // |a|: multiplicand, or dividend/quotient shifter
  logic [WIDTH-1:0]   opb_q;         // |b|: multiplier shifter, or divisor
  logic [2*WIDTH-1:0] acc_q;         // product, or remainder in upper half
  logic               neg_res_q, neg_rem_q, divz_q;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               op_valid;
  logic               is_div, is_signed;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc_d;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_diff;
  logic [2*WIDTH-1:0] div_acc_d;
  logic [WIDTH-1:0]   div_opa_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   hi_d, lo_d;

  // Operand conditioning, one iteration step of each algorithm, and final sign fix-up.
  always_comb begin
    op_valid  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    is_div    = op_q[1];
    is_signed = ~op_q[0];
    abs_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    abs_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (opb_q[0] ? {1'b0, opa_q} : '0);
    mul_acc_d = {mul_sum, acc_q[WIDTH-1:1]};

    rem_sh    = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]};
    rem_ge    = rem_sh >= {1'b0, opb_q};
    rem_diff  = rem_sh[WIDTH-1:0] - opb_q;
    div_acc_d = {(rem_ge ? rem_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-1:0]};
    div_opa_d = {opa_q[WIDTH-2:0], rem_ge};

    prod_fix  = neg_res_q ? -acc_q : acc_q;
    quo_fix   = neg_res_q ? -opa_q : opa_q;
    rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    if (!is_div) begin
      hi_d = prod_fix[2*WIDTH-1:WIDTH];
      lo_d = prod_fix[WIDTH-1:0];
    end else if (divz_q) begin
      hi_d = a_q;
      lo_d = '1;
    end else begin
      hi_d = rem_fix;
      lo_d = quo_fix;
    end
  end

  // Control FSM and datapath registers; handshake outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start && op_valid) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op[1:0];
            busy_q  <= 1'b1;
            state_q <= S_PREP;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_PREP: begin
          opa_q     <= abs_a;
          opb_q     <= abs_b;
          neg_res_q <= is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_rem_q <= is_signed && a_q[WIDTH-1];
          divz_q    <= is_div && (b_q == '0);
          acc_q     <= '0;
          cnt_q     <= '0;
          state_q   <= S_RUN;
        end
        S_RUN: begin
          if (is_div) begin
            acc_q <= div_acc_d;
            opa_q <= div_opa_d;
          end else begin
            acc_q <= mul_acc_d;
            opb_q <= opb_q >> 1;
          end
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against a
// plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int cyc      = 0;
  int bad      = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  // Reference: {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [4:0] mop, input logic [31:0] ma, input logic [31:0] mb);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]     res;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    ua = {32'd0, ma};
    ub = {32'd0, mb};
    res = '0;
    case (mop)
      5'd16: res = sa * sb;
      5'd17: res = ua * ub;
      5'd18: begin
        if (mb == 32'd0) res = {ma, 32'hFFFFFFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          res = {sr[31:0], sq[31:0]};
        end
      end
      5'd19: begin
        if (mb == 32'd0) res = {ma, 32'hFFFFFFFF};
        else res = {32'(ua % ub), 32'(ua / ub)};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for done; called #1 after the accepting edge. n = edges until done seen.
  // Flags bad if busy drops, done rises early, or hi/lo move before done.
  task automatic wait_done(output int n);
    logic [31:0] h0, l0;
    h0 = hi;
    l0 = lo;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      if (busy !== 1'b1 || hi !== h0 || lo !== l0) bad++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Full transaction with operand scrambling after acceptance.
  task automatic run_op(input string tag, input logic [4:0] top, input logic [31:0] ta, input logic [31:0] tb);
    int n;
    logic [63:0] exp;
    exp = model(top, ta, tb);
    start = 1'b1; op = top; a = ta; b = tb;
    @(posedge clk); #1;
    start = 1'b0; op = 5'(16 + $urandom_range(0, 3)); a = $urandom; b = $urandom;
    bad = 0;
    wait_done(n);
    chk({tag, "_lat"}, 64'(n), 64'd34);
    chk({tag, "_win"}, 64'(bad), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_res"}, {hi, lo}, exp);
  endtask

  initial begin
    int n, n2, c1, dc;
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] exp1, exp2;

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset", {28'd0, busy, done, 2'b00, hi, lo}, 64'd0);

    run_op("multu_max", 5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("mult_neg",  5'd16, 32'hFFFFFFFD, 32'd5);
    run_op("divu_100_7", 5'd19, 32'd100, 32'd7);
    run_op("div_m7_2",  5'd18, 32'hFFFFFFF9, 32'd2);
    run_op("div_ovf",   5'd18, 32'h80000000, 32'hFFFFFFFF);
    run_op("divu_z",    5'd19, 32'd5, 32'd0);
    run_op("div_z_neg", 5'd18, 32'hFFFFFF00, 32'd0);
    run_op("mult_min",  5'd16, 32'h80000000, 32'h80000000);

    // start pulsed while busy must be ignored
    exp1 = model(5'd17, 32'h12345678, 32'h9ABCDEF0);
    start = 1'b1; op = 5'd17; a = 32'h12345678; b = 32'h9ABCDEF0;
    @(posedge clk); #1;
    start = 1'b0;
    dc = done_cnt;
    repeat (5) @(posedge clk);
    #1 start = 1'b1; op = 5'd19; a = 32'd77; b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    bad = 0;
    wait_done(n);
    chk("ign_lat", 64'(n), 64'd28);
    chk("ign_res", {hi, lo}, exp1);
    repeat (45) @(posedge clk);
    #1 chk("ign_once", 64'(done_cnt - dc), 64'd1);

    // start held high through DONE: second op accepted back-to-back
    exp1 = model(5'd16, 32'hDEADBEEF, 32'h00001234);
    exp2 = model(5'd18, 32'h7FFFFFFF, 32'hFFFFFFF0);
    start = 1'b1; op = 5'd16; a = 32'hDEADBEEF; b = 32'h00001234;
    @(posedge clk); #1;
    op = 5'd18; a = 32'h7FFFFFFF; b = 32'hFFFFFFF0;
    bad = 0;
    wait_done(n);
    c1 = cyc;
    chk("b2b_lat1", 64'(n), 64'd34);
    chk("b2b_res1", {hi, lo}, exp1);
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    chk("b2b_busy", {busy, done}, 64'b10);
    wait_done(n2);
    chk("b2b_gap", 64'(cyc - c1), 64'd35);
    chk("b2b_win", 64'(bad), 64'd0);
    chk("b2b_res2", {hi, lo}, exp2);

    // invalid op is ignored
    exp1 = {hi, lo};
    start = 1'b1; op = 5'd3; a = 32'd9; b = 32'd9;
    @(posedge clk); #1 start = 1'b0;
    chk("inv_busy", {busy, done}, 64'd0);
    repeat (3) @(posedge clk);
    #1 chk("inv_hold", {hi, lo, 30'd0, busy, done}, {exp1, 32'd0});

    // randomized ops with corner-biased operands
    for (int i = 0; i < 24; i++) begin
      rop = 5'(16 + $urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h80000000;
        3: rb = 32'hFFFFFFFF;
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), rop, ra, rb);
    end

    // reset mid-operation aborts without a done
    start = 1'b1; op = 5'd17; a = 32'hFFFF0000; b = 32'h0000FFFF;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_abort", {28'd0, busy, done, 2'b00, hi, lo}, 64'd0);
    dc = done_cnt;
    repeat (45) @(posedge clk);
    #1 chk("rst_nodone", 64'(done_cnt - dc), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit that sits beside the ALU in the CPU datapath, downstream of decode. It consumes the same operand pair and 5-bit op code that the decoder drives to the ALU (a1, b1, op). It produces a 64-bit result as hi/lo. It is a multi-cycle stage with a start/busy/done handshake, so the control FSM can stall while a MULT/DIV instruction completes.

## Interface
- WIDTH, 32, operand width; hi/lo are each WIDTH bits.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when the unit is ready (IDLE or DONE).
- op  in  5  operation: 5'd16 MULT, 5'd17 MULTU, 5'd18 DIV, 5'd19 DIVU; any other value is ignored.
- a  in  WIDTH  operand A: multiplicand or dividend.
- b  in  WIDTH  operand B: multiplier or divisor.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when hi/lo hold a new result.
- hi  out  WIDTH  MULT: upper product word; DIV: remainder.
- lo  out  WIDTH  MULT: lower product word; DIV: quotient.

## Operation
- FSM states are IDLE, PREP, RUN, FIX and DONE.
- IDLE/DONE, on start with a valid op:
  - latch a, b, op;
  - go to PREP.
- IDLE/DONE, on start with an invalid op: no state change, no done.
- DONE with no start: return to IDLE after its single cycle.
- PREP (1 cycle):
  - for signed ops, take |a| and |b|;
  - record the result sign (a[31]^b[31]) and the remainder sign (a[31]);
  - clear the accumulator;
  - load the iteration counter with 0.
- RUN (exactly WIDTH cycles, counter 0..WIDTH-1):
  - multiply: shift-add, one multiplier bit per cycle, LSB first, into a 2*WIDTH-bit accumulator;
  - divide: restoring division, one quotient bit per cycle, MSB first;
  - leave RUN when the counter equals WIDTH-1.
- FIX (1 cycle):
  - signed ops: negate the product, quotient or remainder as recorded;
  - write hi/lo;
  - go to DONE.
- Arithmetic rules:
  - MULT/MULTU: {hi,lo} is the full 64-bit two's-complement or unsigned product.
  - DIV: quotient truncates toward zero; remainder takes the dividend's sign; a == q*b + r.
  - Division by zero (DIV or DIVU): lo = 32'hFFFFFFFF, hi = a. Normal latency, no error flag.
  - DIV of 32'h80000000 by 32'hFFFFFFFF: lo = 32'h80000000, hi = 0.
- hi/lo hold their value until the next FIX writes them. They never change in any other state.
- start while busy is ignored. The request is not queued.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0, state=IDLE. rst mid-operation aborts the operation; no done follows it.
- Let edge E be the edge at which start is accepted. Then:
  - busy=1 in the 34 cycles after E (PREP 1 + RUN 32 + FIX 1);
  - hi/lo update at edge E+34;
  - done=1 and busy=0 during the cycle after E+34.
- Total latency from the start edge to done is 35 cycles. It is fixed for every op and operand value, including divide-by-zero.
- done and busy are never high together.
- Back-to-back: start held high in the DONE cycle is accepted. The next done then comes exactly 35 cycles after the previous done.
- a, b and op may change after the accepting edge. Only the latched copies are used.

## Test plan
- MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> done at start+35, hi=32'hFFFFFFFE, lo=32'h00000001.
- MULT a=-3, b=5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1.
- DIVU a=100, b=7 -> lo=14, hi=2.
- DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- DIV overflow case (a=32'h80000000, b=-1) -> lo=32'h80000000, hi=0.
- DIVU a=5, b=0 -> lo=32'hFFFFFFFF, hi=5, at normal latency.
- Control behaviour:
  - start pulsed again while busy -> ignored, only one done;
  - start held through DONE -> second result exactly 35 cycles later;
  - op=5'd3 with start -> busy stays 0;
  - rst asserted at start+10 -> busy/done/hi/lo are 0 next cycle, and no done appears afterwards.
